// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// FSM states, opcode/funct values, ALU operation codes and the control bundle.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // br_cand / en_fin / en_mem are qualified by zero / mem_ready at the output
    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       alu_scr;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic [3:0] alu_op;
        logic       br_cand;
        logic       en_fin;
        logic       en_mem;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of the latched opcode/funct into an ALU operation
// and a legal-instruction flag.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_AND;
        legal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
                    FN_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
                    FN_AND: begin alu_op = ALU_AND; legal = 1'b1; end
                    FN_OR:  begin alu_op = ALU_OR;  legal = 1'b1; end
                    FN_SLT: begin alu_op = ALU_SLT; legal = 1'b1; end
                    default: ;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: begin alu_op = ALU_ADD; legal = 1'b1; end
            OP_BEQ:                begin alu_op = ALU_SUB; legal = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle MIPS main control FSM with illegal-opcode trap and retire counter.
// Optional CTRL_MEM_WAIT_EN adds mem_ready and stretches MEM until it is high.
module control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
`ifdef CTRL_MEM_WAIT_EN
    input  logic                mem_ready,
`endif
    output logic                en,
    output logic                Branch,
    output logic                RegDst,
    output logic                regWrite,
    output logic                alu_scr,
    output logic [3:0]          alu_op,
    output logic                MemToReg,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_t              state_q, state_d;
    logic [5:0]          ir_op_q, ir_op_d;
    logic [5:0]          ir_fn_q, ir_fn_d;
    logic                illegal_q, illegal_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [3:0]          dec_alu_op;
    logic                dec_legal;
    logic                mem_ok;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    alu_decoder u_alu_decoder (
        .opcode (ir_op_q),
        .funct  (ir_fn_q),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    // Control values for the state about to be entered, so outputs come from flops
    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op,
                                       input logic [3:0] aop);
        ctrl_t c;
        c = '0;
        case (s)
            S_EXEC: begin
                c.alu_op  = aop;
                c.alu_scr = (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
                c.br_cand = (op == OP_BEQ);
                c.en_fin  = (op == OP_BEQ);
            end
            S_MEM: begin
                c.alu_op    = aop;
                c.alu_scr   = 1'b1;
                c.mem_read  = (op == OP_LW);
                c.mem_write = (op == OP_SW);
                c.en_mem    = (op == OP_SW);
            end
            S_WB: begin
                c.alu_op     = aop;
                c.en_fin     = 1'b1;
                c.reg_write  = 1'b1;
                c.reg_dst    = (op == OP_RTYPE);
                c.alu_scr    = (op == OP_ADDI) || (op == OP_LW);
                c.mem_read   = (op == OP_LW);
                c.mem_to_reg = (op == OP_LW);
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        ir_op_d   = ir_op_q;
        ir_fn_d   = ir_fn_q;
        retired_d = retired_q + RETIRE_W'(en);
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
                ir_op_d = opcode;
                ir_fn_d = funct;
            end
            S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (ir_op_q == OP_LW || ir_op_q == OP_SW) state_d = S_MEM;
                else if (ir_op_q == OP_BEQ)               state_d = S_FETCH;
                else                                      state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ok) state_d = (ir_op_q == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
        ctrl_d    = ctrl_for(state_d, ir_op_q, dec_alu_op);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_op_q   <= '0;
            ir_fn_q   <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            ir_op_q   <= ir_op_d;
            ir_fn_q   <= ir_fn_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign en       = ctrl_q.en_fin | (ctrl_q.en_mem & mem_ok);
    assign Branch   = ctrl_q.br_cand & zero;
    assign RegDst   = ctrl_q.reg_dst;
    assign regWrite = ctrl_q.reg_write;
    assign alu_scr  = ctrl_q.alu_scr;
    assign alu_op   = ctrl_q.alu_op;
    assign MemToReg = ctrl_q.mem_to_reg;
    assign MemWrite = ctrl_q.mem_write;
    assign MemRead  = ctrl_q.mem_read;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed, table-driven bench for control_fsm plus hand-written reset,
// trap, memory-wait and counter-wrap sequences.
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic        zero = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    logic        mem_ready = 1'b1;
`endif

    logic        en, Branch, RegDst, regWrite, alu_scr, MemToReg, MemWrite, MemRead, illegal;
    logic [3:0]  alu_op;
    logic [31:0] retired;

    logic        en4, Branch4, RegDst4, regWrite4, alu_scr4, MemToReg4, MemWrite4, MemRead4, illegal4;
    logic [3:0]  alu_op4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    control_fsm #(.RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .en(en), .Branch(Branch), .RegDst(RegDst), .regWrite(regWrite),
        .alu_scr(alu_scr), .alu_op(alu_op), .MemToReg(MemToReg),
        .MemWrite(MemWrite), .MemRead(MemRead), .illegal(illegal), .retired(retired)
    );

    control_fsm #(.RETIRE_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .en(en4), .Branch(Branch4), .RegDst(RegDst4), .regWrite(regWrite4),
        .alu_scr(alu_scr4), .alu_op(alu_op4), .MemToReg(MemToReg4),
        .MemWrite(MemWrite4), .MemRead(MemRead4), .illegal(illegal4), .retired(retired4)
    );

    // {en, Branch, RegDst, regWrite, alu_scr, MemRead, MemWrite, MemToReg, alu_op, illegal}
    logic [12:0] act;
    assign act = {en, Branch, RegDst, regWrite, alu_scr, MemRead, MemWrite, MemToReg, alu_op, illegal};

    localparam logic [3:0]  A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                            A_SUB = 4'b0110, A_SLT = 4'b0111;
    localparam logic [12:0] Z = 13'b0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic [12:0] exp;
        int          ret;
    } vec_t;

    vec_t vecs[$];
    int   ntests = 0;
    int   nfail  = 0;

    function automatic logic [12:0] e(input logic p_en, p_br, p_rd, p_rw, p_as, p_mr,
                                      p_mw, p_m2r, input logic [3:0] p_op, input logic p_ill);
        return {p_en, p_br, p_rd, p_rw, p_as, p_mr, p_mw, p_m2r, p_op, p_ill};
    endfunction

    task automatic v(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [12:0] ex, input int ret);
        vec_t t;
        t.op = op; t.fn = fn; t.z = z; t.exp = ex; t.ret = ret;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [12:0] ex, input int ret);
        ntests++;
        if (act !== ex || retired !== 32'(ret)) begin
            nfail++;
            $display("FAIL %s: outputs=%b retired=%0d, required outputs=%b retired=%0d",
                     name, act, retired, ex, ret);
        end
    endtask

    // Called at posedge+1; each entry covers one clock cycle
    task automatic run(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op;
            funct  = vecs[i].fn;
            zero   = vecs[i].z;
            #2;
            chk($sformatf("%s[%0d]", name, i), vecs[i].exp, vecs[i].ret);
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #3;
        chk("reset_state", Z, 0);
        do_reset();

        // add, lw, sw, beq z=1, beq z=0, addi, sub, and, or, slt(zero=1 ignored)
        v(6'h00, 6'h20, 0, Z, 0);
        v(6'h00, 6'h20, 0, Z, 0);
        v(6'h00, 6'h20, 0, e(0,0,0,0,0,0,0,0,A_ADD,0), 0);
        v(6'h00, 6'h20, 0, e(1,0,1,1,0,0,0,0,A_ADD,0), 0);
        v(6'h23, 6'h00, 0, Z, 1);
        v(6'h23, 6'h00, 0, Z, 1);
        v(6'h23, 6'h00, 0, e(0,0,0,0,1,0,0,0,A_ADD,0), 1);
        v(6'h23, 6'h00, 0, e(0,0,0,0,1,1,0,0,A_ADD,0), 1);
        v(6'h23, 6'h00, 0, e(1,0,0,1,1,1,0,1,A_ADD,0), 1);
        v(6'h2B, 6'h00, 0, Z, 2);
        v(6'h2B, 6'h00, 0, Z, 2);
        v(6'h2B, 6'h00, 0, e(0,0,0,0,1,0,0,0,A_ADD,0), 2);
        v(6'h2B, 6'h00, 0, e(1,0,0,0,1,0,1,0,A_ADD,0), 2);
        v(6'h04, 6'h00, 0, Z, 3);
        v(6'h04, 6'h00, 0, Z, 3);
        v(6'h04, 6'h00, 1, e(1,1,0,0,0,0,0,0,A_SUB,0), 3);
        v(6'h04, 6'h00, 0, Z, 4);
        v(6'h04, 6'h00, 0, Z, 4);
        v(6'h04, 6'h00, 0, e(1,0,0,0,0,0,0,0,A_SUB,0), 4);
        v(6'h08, 6'h00, 0, Z, 5);
        v(6'h08, 6'h00, 0, Z, 5);
        v(6'h08, 6'h00, 0, e(0,0,0,0,1,0,0,0,A_ADD,0), 5);
        v(6'h08, 6'h00, 0, e(1,0,0,1,1,0,0,0,A_ADD,0), 5);
        v(6'h00, 6'h22, 0, Z, 6);
        v(6'h00, 6'h22, 0, Z, 6);
        v(6'h00, 6'h22, 0, e(0,0,0,0,0,0,0,0,A_SUB,0), 6);
        v(6'h00, 6'h22, 0, e(1,0,1,1,0,0,0,0,A_SUB,0), 6);
        v(6'h00, 6'h24, 0, Z, 7);
        v(6'h00, 6'h24, 0, Z, 7);
        v(6'h00, 6'h24, 0, e(0,0,0,0,0,0,0,0,A_AND,0), 7);
        v(6'h00, 6'h24, 0, e(1,0,1,1,0,0,0,0,A_AND,0), 7);
        v(6'h00, 6'h25, 0, Z, 8);
        v(6'h00, 6'h25, 0, Z, 8);
        v(6'h00, 6'h25, 0, e(0,0,0,0,0,0,0,0,A_OR,0), 8);
        v(6'h00, 6'h25, 0, e(1,0,1,1,0,0,0,0,A_OR,0), 8);
        v(6'h00, 6'h2A, 1, Z, 9);
        v(6'h00, 6'h2A, 1, Z, 9);
        v(6'h00, 6'h2A, 1, e(0,0,0,0,0,0,0,0,A_SLT,0), 9);
        v(6'h00, 6'h2A, 1, e(1,0,1,1,0,0,0,0,A_SLT,0), 9);
        v(6'h00, 6'h20, 0, Z, 10);
        run("main");

        // Illegal opcode: trap after FETCH, DECODE; sticky until reset
        do_reset();
        v(6'h3F, 6'h00, 0, Z, 0);
        v(6'h3F, 6'h00, 0, Z, 0);
        for (int i = 0; i < 5; i++) v(6'h3F, 6'h00, 0, e(0,0,0,0,0,0,0,0,A_AND,1), 0);
        run("trap_op3f");
        #2 rst = 1'b1;
        #1 chk("trap_op3f_rst", Z, 0);
        @(posedge clk); #1 rst = 1'b0;
        v(6'h00, 6'h20, 0, Z, 0);
        v(6'h00, 6'h20, 0, Z, 0);
        v(6'h00, 6'h20, 0, e(0,0,0,0,0,0,0,0,A_ADD,0), 0);
        v(6'h00, 6'h20, 0, e(1,0,1,1,0,0,0,0,A_ADD,0), 0);
        v(6'h00, 6'h01, 0, Z, 1);
        v(6'h00, 6'h01, 0, Z, 1);
        for (int i = 0; i < 4; i++) v(6'h00, 6'h01, 0, e(0,0,0,0,0,0,0,0,A_AND,1), 1);
        run("after_trap_then_fn01");
        #2 rst = 1'b1;
        #1 chk("trap_fn01_rst", Z, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Reset in lw MEM: immediate zero outputs, no write, no retire
        v(6'h23, 6'h00, 0, Z, 0);
        v(6'h23, 6'h00, 0, Z, 0);
        v(6'h23, 6'h00, 0, e(0,0,0,0,1,0,0,0,A_ADD,0), 0);
        run("lw_pre_abort");
        #2 chk("lw_mem_before_rst", e(0,0,0,0,1,1,0,0,A_ADD,0), 0);
        rst = 1'b1;
        #1 chk("lw_mem_async_rst", Z, 0);
        @(posedge clk); #1 rst = 1'b0;
        v(6'h00, 6'h20, 0, Z, 0);
        v(6'h00, 6'h20, 0, Z, 0);
        run("lw_post_abort");

`ifdef CTRL_MEM_WAIT_EN
        do_reset();
        v(6'h2B, 6'h00, 0, Z, 0);
        v(6'h2B, 6'h00, 0, Z, 0);
        v(6'h2B, 6'h00, 0, e(0,0,0,0,1,0,0,0,A_ADD,0), 0);
        run("sw_wait_pre");
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) v(6'h2B, 6'h00, 0, e(0,0,0,0,1,0,1,0,A_ADD,0), 0);
        run("sw_wait_hold");
        mem_ready = 1'b1;
        v(6'h2B, 6'h00, 0, e(1,0,0,0,1,0,1,0,A_ADD,0), 0);
        v(6'h2B, 6'h00, 0, Z, 1);
        run("sw_wait_ready");
`endif

        // 17 addi on both counter widths: 4-bit wraps to 1
        do_reset();
        opcode = 6'h08; funct = 6'h00; zero = 1'b0;
        repeat (68) @(posedge clk);
        #1;
        ntests++;
        if (retired4 !== 4'd1) begin
            nfail++;
            $display("FAIL retire_wrap4: retired=%0d, required 1", retired4);
        end
        ntests++;
        if (retired !== 32'd17) begin
            nfail++;
            $display("FAIL retire_17: retired=%0d, required 17", retired);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
